ram_main: RTL and testbench



---
 rtl/ram_main_pkg.sv | 13 +
 rtl/ram_main_clear_fsm.sv | 54 +++++
 rtl/ram_main.sv | 70 +++++++
 tb/tb_ram_main.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_main_pkg.sv
// Shared constants and clear-engine state type for the main data memory.
package ram_main_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/ram_main_clear_fsm.sv
// Power-on clear engine: sweeps GND into every word after reset when RAM_MAIN_CLEAR_EN
// is defined; otherwise the FSM resets to IDLE and never leaves it.
module ram_main_clear_fsm #(
  parameter int ADDR_W = ram_main_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              nRESET,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              busy
);
  import ram_main_pkg::*;

`ifdef RAM_MAIN_CLEAR_EN
  localparam clr_state_e RESET_STATE = CLEAR;
`else
  localparam clr_state_e RESET_STATE = IDLE;
`endif

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    busy    = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        busy   = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        // Last word written on this edge; the counter wraps back to zero.
        if (cnt_q == '1) begin
          state_d = IDLE;
        end
      end
      default: ;
    endcase
  end

  assign clr_addr = cnt_q;

endmodule

// File: rtl/ram_main.sv
// Single-port synchronous RAM on a shared tri-state data bus (optional power-on
// clear via RAM_MAIN_CLEAR_EN, implemented in ram_main_clear_fsm).
module ram_main #(
  parameter int ADDR_W = ram_main_pkg::ADDR_W,
  parameter int DATA_W = ram_main_pkg::DATA_W
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              Wr,
  input  logic              Rd,
  input  logic [ADDR_W-1:0] MemADDR,
  inout  wire  [DATA_W-1:0] ToFromW,
  input  logic [DATA_W-1:0] GND
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              oe_q, oe_d;

  logic              clr_we;
  logic              busy;
  logic [ADDR_W-1:0] clr_addr;

  logic              user_wr, user_rd, mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  ram_main_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .CLK      (CLK),
    .nRESET   (nRESET),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .busy     (busy)
  );

  // Simultaneous Wr and Rd is a no-op so the bus is never fought over.
  always_comb begin
    user_wr   = Wr && !Rd && !busy;
    user_rd   = Rd && !Wr && !busy;
    mem_we    = clr_we || user_wr;
    mem_waddr = clr_we ? clr_addr : MemADDR;
    mem_wdata = clr_we ? GND : ToFromW;
    rdata_d   = user_rd ? mem[MemADDR] : rdata_q;
    oe_d      = user_rd;
  end

  // Contents survive reset, but an edge seen while nRESET is low must not write.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
    end else if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      rdata_q <= '0;
      oe_q    <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      oe_q    <= oe_d;
    end
  end

  assign ToFromW = oe_q ? rdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_main.sv
// Scoreboard bench for ram_main: random and directed bus traffic against an array model;
// covers the RAM_MAIN_CLEAR_EN sweep when that macro is defined.
module tb_ram_main;

  localparam logic [15:0] BUS_Z = 16'hFFFF;  // released bus as seen through the pull-up

  typedef struct {
    int          due;
    logic [15:0] exp;
    string       tag;
  } exp_t;

  logic        CLK;
  logic        nRESET;
  logic        Wr;
  logic        Rd;
  logic [9:0]  MemADDR;
  logic [15:0] gnd_pat;
  logic        tb_drv;
  logic [15:0] tb_data;
  tri1  [15:0] bus;

  assign bus = tb_drv ? tb_data : 16'hzzzz;

  ram_main dut (
    .CLK     (CLK),
    .nRESET  (nRESET),
    .Wr      (Wr),
    .Rd      (Rd),
    .MemADDR (MemADDR),
    .ToFromW (bus),
    .GND     (gnd_pat)
  );

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  exp_t        sb[$];
  exp_t        mon_e;

  logic [15:0] model_mem [1024];
  bit          known     [1024];
  bit          all_known = 0;
  int          wlist[$];
  bit          prev_rd   = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc = cyc + 1;

  // Monitor: at each falling edge, compare every expectation due this cycle.
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e  = sb.pop_front();
      checks = checks + 1;
      if (mon_e.due != cyc) begin
        failures = failures + 1;
        $display("FAIL %s missed: due cycle %0d, now %0d", mon_e.tag, mon_e.due, cyc);
      end else if (bus !== mon_e.exp) begin
        failures = failures + 1;
        $display("FAIL %s cyc=%0d bus=%h expected=%h", mon_e.tag, cyc, bus, mon_e.exp);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic push(input int due, input logic [15:0] exp, input string tag);
    exp_t e;
    e.due = due;
    e.exp = exp;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // One bus cycle; called and returns at negedge+1.
  task automatic step(input bit wr, input bit rd, input int addr, input logic [15:0] data,
                      input logic [15:0] exp, input string tag);
    Wr      = wr;
    Rd      = rd;
    MemADDR = addr[9:0];
    tb_drv  = wr;
    tb_data = data;
    push(cyc + 1, exp, tag);
    @(posedge CLK);
    #1;
    tb_drv = 1'b0;
    @(negedge CLK);
    #1;
  endtask

  // Model-level operation; a bench write right after a DUT read gets an idle gap first.
  task automatic op(input bit wr, input bit rd, input int addr, input logic [15:0] data,
                    input bit ignored, input string tag);
    logic [15:0] exp;
    if (prev_rd && wr) begin
      step(1'b0, 1'b0, 0, 16'h0000, BUS_Z, "gap_idle");
      prev_rd = 0;
    end
    exp = BUS_Z;
    if (!ignored) begin
      if (wr && !rd) begin
        model_mem[addr] = data;
        if (!known[addr]) wlist.push_back(addr);
        known[addr] = 1;
      end else if (rd && !wr) begin
        exp = model_mem[addr];
      end
    end
    step(wr, rd, addr, data, exp, tag);
    prev_rd = rd && !wr && !ignored;
  endtask

  task automatic random_op(input bit ignored);
    int          kind;
    int          a;
    logic [15:0] d;
    kind = $urandom_range(0, 9);
    d    = 16'($urandom());
    a    = $urandom_range(0, 1023);
    if (kind >= 4 && kind <= 7) begin
      if (all_known || ignored) begin
        op(1'b0, 1'b1, a, d, ignored, "rand_rd");
      end else if (wlist.size() > 0) begin
        a = wlist[$urandom_range(0, wlist.size() - 1)];
        op(1'b0, 1'b1, a, d, ignored, "rand_rd");
      end else begin
        op(1'b1, 1'b0, a, d, ignored, "rand_wr");
      end
    end else if (kind < 4) begin
      op(1'b1, 1'b0, a, d, ignored, "rand_wr");
    end else if (kind == 8) begin
      op(1'b1, 1'b1, a, d, ignored, "rand_both");
    end else begin
      op(1'b0, 1'b0, a, d, ignored, "rand_idle");
    end
  endtask

  // Called right after reset release: 1024 ignored edges, then everything reads GND.
  task automatic clear_phase();
`ifdef RAM_MAIN_CLEAR_EN
    for (int i = 0; i < 1024; i++) begin
      model_mem[i] = gnd_pat;
      known[i]     = 1;
    end
    all_known = 1;
    prev_rd   = 0;
    for (int i = 0; i < 1024; i++) random_op(1'b1);
    op(1'b0, 1'b1, 0,    16'h0, 1'b0, "clr_rd0");
    op(1'b0, 1'b1, 511,  16'h0, 1'b0, "clr_rd511");
    op(1'b0, 1'b1, 1023, 16'h0, 1'b0, "clr_rd1023");
    op(1'b0, 1'b0, 0,    16'h0, 1'b0, "clr_idle");
`endif
  endtask

  // Read, then drop reset mid-cycle: bus must release before the next edge.
  task automatic reset_mid_read(input int addr);
    Wr      = 1'b0;
    Rd      = 1'b1;
    MemADDR = addr[9:0];
    push(cyc + 1, BUS_Z, "rst_bus_release");
    @(posedge CLK);
    #2;
    checks = checks + 1;
    if (bus !== model_mem[addr]) begin
      failures = failures + 1;
      $display("FAIL read_before_rst bus=%h expected=%h", bus, model_mem[addr]);
    end
    nRESET = 1'b0;
    @(negedge CLK);
    #1;
    // Write attempted while reset is held must be lost.
    Rd      = 1'b0;
    Wr      = 1'b1;
    tb_drv  = 1'b1;
    tb_data = ~model_mem[addr];
    push(cyc + 1, BUS_Z, "rst_hold_bus");
    @(posedge CLK);
    #1;
    tb_drv = 1'b0;
    Wr     = 1'b0;
    @(negedge CLK);
    #1;
    nRESET  = 1'b1;
    prev_rd = 0;
  endtask

  initial begin
    nRESET  = 1'b0;
    Wr      = 1'b0;
    Rd      = 1'b0;
    MemADDR = '0;
    gnd_pat = 16'h0000;
    tb_drv  = 1'b0;
    tb_data = 16'h0000;
    for (int i = 0; i < 1024; i++) begin
      model_mem[i] = 16'h0000;
      known[i]     = 0;
    end

    @(posedge CLK);
    #1;
    push(cyc, BUS_Z, "reset_bus_z");
    @(posedge CLK);
    @(negedge CLK);
    #1;
    nRESET = 1'b1;
    clear_phase();

    op(1'b1, 1'b0, 5, 16'hA5A5, 1'b0, "wr_a5a5");
    op(1'b0, 1'b1, 5, 16'h0000, 1'b0, "rd_a5a5");
    op(1'b0, 1'b0, 0, 16'h0000, 1'b0, "after_rd_z");

    op(1'b1, 1'b0, 0,    16'h1234, 1'b0, "wr_lo");
    op(1'b1, 1'b0, 1023, 16'hBEEF, 1'b0, "wr_hi");
    op(1'b0, 1'b1, 0,    16'h0000, 1'b0, "b2b_rd_lo");
    op(1'b0, 1'b1, 1023, 16'h0000, 1'b0, "b2b_rd_hi");
    op(1'b0, 1'b0, 0,    16'h0000, 1'b0, "b2b_idle_z");

    op(1'b1, 1'b0, 7, 16'h0001, 1'b0, "wr_7");
    op(1'b1, 1'b1, 7, 16'hFFFF, 1'b0, "conflict_no_drive");
    op(1'b0, 1'b1, 7, 16'h0000, 1'b0, "rd_7_kept");
    op(1'b0, 1'b0, 0, 16'h0000, 1'b0, "idle_pullup");

    for (int i = 0; i < 300; i++) random_op(1'b0);
    op(1'b0, 1'b0, 0, 16'h0000, 1'b0, "pre_rst_idle");

    if (model_mem[5] == 16'hFFFF) op(1'b1, 1'b0, 5, 16'h5A5A, 1'b0, "wr_5_fix");
    reset_mid_read(5);
    clear_phase();
    op(1'b0, 1'b1, 5, 16'h0000, 1'b0, "rd_after_rst");
    for (int i = 0; i < 100; i++) random_op(1'b0);
    op(1'b0, 1'b0, 0, 16'h0000, 1'b0, "final_idle");

    repeat (3) @(negedge CLK);
    #1;
    checks = checks + 1;
    if (sb.size() != 0) begin
      failures = failures + 1;
      $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
